// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer valid/ready/last streams plus the shared FIFO write port.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) ();
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [ID_W+DATA_WIDTH-1:0]    fifo_wdata;
  logic                          fifo_full;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic                          timeout;
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wdata, grant_id, busy, timeout
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wdata, grant_id, busy, timeout
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port, tagging each word with its source id.
module fifo_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  fifo_write_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int IW   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state;
  logic [ID_W-1:0] grant_id, rr_last, winner, cand;
  logic [BW-1:0]   beat_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            busy, timeout, active, valid_g, last_g, xfer;
  // ready/wr_en are gated by rst_n so nothing is accepted during a reset cycle
  assign active  = rst_n && state == BURST && !bus.fifo_full;
  assign valid_g = bus.req_valid[grant_id];
  assign last_g  = bus.req_last[grant_id];
  assign xfer    = active && valid_g;
  assign bus.req_ready  = active ? NUM_REQ'(1) << grant_id : '0;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_wdata = {grant_id, bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH]};
  assign bus.grant_id   = grant_id;
  assign bus.busy       = busy;
  assign bus.timeout    = timeout;
  // scan from lowest to highest priority so the highest-priority valid wins
  always_comb begin
    winner = rr_last;
    cand   = rr_last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(rr_last) + i) % NUM_REQ);
      if (bus.req_valid[cand]) winner = cand;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
      idle_cnt <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|bus.req_valid) begin
          grant_id <= winner;
          beat_cnt <= '0;
          idle_cnt <= '0;
          state    <= BURST;
          busy     <= 1'b1;
        end
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
        idle_cnt <= '0;
        if (last_g || beat_cnt == BEAT_LAST) begin
          state   <= IDLE;
          busy    <= 1'b0;
          rr_last <= grant_id;
        end
      end else if (!valid_g) begin
        if (idle_cnt == IDLE_LAST) begin
          state   <= IDLE;
          busy    <= 1'b0;
          rr_last <= grant_id;
          timeout <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end
endmodule
